// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war board logic.
package tug_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // 10 ms of stable level at 50 MHz
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous level inputs (keys, switches).
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounces one active-low push-button into a clean level plus press/release strobes.
module key_conditioner
  import tug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_t       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             press_nxt, release_nxt;
  logic             key_level;
  logic             s;

  assign key_level = ~key_n;

  sync2 #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_level),
    .q     (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      pressed       <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES further samples agree with the first change.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          count_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (count == CNT_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          count_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = HELD;
        end else if (count == CNT_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with DEBOUNCE_CYCLES=4.
module tb_key_conditioner;
  import tug_pkg::*;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_n = 1'b1;
  logic pressed, press_pulse, release_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n         (key_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  // Reference: raw samples delayed two edges, level flips after N+1 consecutive disagreeing samples.
  logic q_sync[$];
  logic m_level, m_press, m_release;
  int   m_run;

  task automatic model_reset();
    q_sync.delete();
    q_sync.push_back(1'b0);
    q_sync.push_back(1'b0);
    m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_run = 0;
  endtask

  task automatic model_edge(input logic raw_n);
    logic obs;
    obs = q_sync.pop_front();
    q_sync.push_back(~raw_n);
    m_press = 1'b0;
    m_release = 1'b0;
    if (obs != m_level) m_run++;
    else m_run = 0;
    if (m_run == int'(N) + 1) begin
      m_level = ~m_level;
      m_run = 0;
      if (m_level) m_press = 1'b1;
      else m_release = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-sequence pulse statistics
  int  n_press, n_release, press_at, release_at, seq_cyc, wide;
  logic prev_pp, prev_rp;

  task automatic seq_start();
    n_press = 0; n_release = 0; press_at = -1; release_at = -1; seq_cyc = 0;
  endtask

  task automatic cycle(input logic k, input logic r, input string tag);
    @(negedge clk);
    key_n = k;
    rst_n = r;
    @(posedge clk);
    if (rst_n) model_edge(k);
    else model_reset();
    #1;
    check($sformatf("%s_pressed", tag), pressed, m_level);
    check($sformatf("%s_press_pulse", tag), press_pulse, m_press);
    check($sformatf("%s_release_pulse", tag), release_pulse, m_release);
    if (press_pulse) begin
      n_press++;
      if (press_at < 0) press_at = seq_cyc;
    end
    if (release_pulse) begin
      n_release++;
      if (release_at < 0) release_at = seq_cyc;
    end
    if ((press_pulse && prev_pp) || (release_pulse && prev_rp)) wide++;
    prev_pp = press_pulse;
    prev_rp = release_pulse;
    seq_cyc++;
  endtask

  typedef struct {
    logic key_n;
    logic exp_pressed;
    logic exp_press;
    logic exp_release;
  } vec_t;

  vec_t tbl[24];

  initial begin
    wide = 0; prev_pp = 1'b0; prev_rp = 1'b0;
    model_reset();
    seq_start();

    // Clean press then release, hand-derived: pulse 6 edges after each key change.
    for (int i = 0; i < 24; i++) begin
      tbl[i].key_n       = (i < 10) ? 1'b0 : 1'b1;
      tbl[i].exp_pressed = (i >= 6) && (i < 16);
      tbl[i].exp_press   = (i == 6);
      tbl[i].exp_release = (i == 16);
    end

    // Reset held with a toggling key
    for (int i = 0; i < 8; i++) cycle(i[0], 1'b0, "rst");
    check("rst_state_idle", dut.state == IDLE, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, "idle");

    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].key_n, 1'b1, "tbl");
      check($sformatf("tbl%0d_pressed", i), pressed, tbl[i].exp_pressed);
      check($sformatf("tbl%0d_press", i), press_pulse, tbl[i].exp_press);
      check($sformatf("tbl%0d_release", i), release_pulse, tbl[i].exp_release);
    end

    // Clean press held for 50 cycles
    seq_start();
    for (int i = 0; i < 56; i++) cycle(1'b0, 1'b1, "hold");
    check_int("hold_press_latency", press_at, 6);
    check_int("hold_press_count", n_press, 1);
    check("hold_pressed", pressed, 1'b1);

    // Short release bounce while held, then clean release
    seq_start();
    cycle(1'b1, 1'b1, "rbounce");
    cycle(1'b1, 1'b1, "rbounce");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, "rbounce");
    check_int("rbounce_release_count", n_release, 0);
    check_int("rbounce_press_count", n_press, 0);
    check("rbounce_pressed", pressed, 1'b1);
    seq_start();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, "release");
    check_int("release_latency", release_at, 6);
    check_int("release_count", n_release, 1);
    check("release_pressed", pressed, 1'b0);

    // Press bounce shorter than the debounce window
    seq_start();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, "pbounce");
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, "pbounce");
    check_int("pbounce_press_count", n_press, 0);
    check("pbounce_pressed", pressed, 1'b0);

    // Asynchronous reset while held, key still down across release
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, "prehold");
    check("prehold_pressed", pressed, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_pressed", pressed, 1'b0);
    check("async_rst_press_pulse", press_pulse, 1'b0);
    check("async_rst_release_pulse", release_pulse, 1'b0);
    prev_pp = 1'b0; prev_rp = 1'b0;
    seq_start();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "inrst");
    check_int("inrst_no_pulse", n_press + n_release, 0);
    seq_start();
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, "rstexit");
    check_int("rstexit_press_latency", press_at, 6);
    check_int("rstexit_press_count", n_press, 1);
    check_int("rstexit_release_count", n_release, 0);

    // Two rapid clean presses
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, "settle");
    seq_start();
    wide = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, "rapid");
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, "rapid");
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, "rapid");
    check_int("rapid_press_count", n_press, 2);
    check_int("rapid_release_count", n_release, 2);
    check_int("rapid_pulse_width", wide, 0);

    // Random bursts of bouncing and stable levels
    for (int r = 0; r < 400; r++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(1, 0));
      len = (($urandom_range(3, 0)) == 0) ? int'($urandom_range(12, 5)) : int'($urandom_range(4, 1));
      for (int i = 0; i < len; i++) cycle(lvl, 1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions one raw active-low push-button into clean game inputs for the tug-of-war board. It synchronises the asynchronous KEY level into the clock domain and debounces it with a per-key counter. It then produces a debounced level and single-cycle press/release strobes. One instance sits between each player key (KEY[3], KEY[0]) and the move-pulse inputs of the light chain and display logic.

## Interface
- DEBOUNCE_CYCLES, default 500000: consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz). Legal range ≥ 1.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; never overridden independently.

- Clock, input, 1: system clock; the top level connects CLOCK_50.
- Reset, input, 1: asynchronous, active-low reset. It clears all state immediately; release is synchronous to Clock at the top level.
- key_n, input, 1: raw button level, 0 = pressed. Asynchronous to Clock and bouncing.
- pressed, output, 1: debounced level, 1 = held.
- press_pulse, output, 1: high for exactly one cycle per accepted press.
- release_pulse, output, 1: high for exactly one cycle per accepted release.

## Operation
- Synchroniser: two flops on ~key_n, reset to 0 (released). The output s is the only signal the FSM sees.
- FSM states:
  - IDLE: s=1 → PRESS_WAIT, count←0.
  - PRESS_WAIT:
    - s=0 → IDLE; this is a bounce, no pulse.
    - s=1 and count==DEBOUNCE_CYCLES-1 → HELD, press_pulse←1.
    - otherwise count++.
  - HELD: s=0 → RELEASE_WAIT, count←0.
  - RELEASE_WAIT:
    - s=1 → HELD; no pulse, and no second press_pulse.
    - s=0 and count==DEBOUNCE_CYCLES-1 → IDLE, release_pulse←1.
    - otherwise count++.
- pressed is registered and equals 1 in HELD and RELEASE_WAIT.
- press_pulse and release_pulse are registered. They are 0 on every cycle except the one following the accepting edge.
- Holding a key never repeats press_pulse. One physical press gives exactly one press_pulse and one release_pulse.
- Count is compared for equality only and never exceeds DEBOUNCE_CYCLES-1, so it does not wrap.

## Timing
- Reset asserted: pressed=0, press_pulse=0, release_pulse=0, state=IDLE, count=0, synchroniser=0.
- Reset mid-debounce or mid-hold: all outputs drop to 0 asynchronously. No pulse is emitted on reset entry or exit.
- Key held across reset release: the key is treated as a new press, giving one press_pulse DEBOUNCE_CYCLES+2 edges after the first edge where key_n=0 is sampled.
- Press latency: key_n falls before edge k, which is the first edge that samples it low.
  - s=1 after edge k+1, and the FSM enters PRESS_WAIT at edge k+2.
  - press_pulse is high in the cycle after edge k+2+DEBOUNCE_CYCLES, and pressed rises on the same edge.
- Release latency is symmetric. release_pulse and pressed=0 appear in the cycle after edge k+2+DEBOUNCE_CYCLES.
- A bounce shorter than DEBOUNCE_CYCLES synchronised samples produces no output change.
- Simultaneous edge and reset: Reset wins.

## Structure
- Shared package tug_pkg:
  - key_state_t enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Constant DEBOUNCE_DEFAULT = 500000.
- Sub-module sync2: a generic two-flop synchroniser with Clock, active-low async Reset, d and q. It is reused for SW inputs later.
- The top level instantiates two key_conditioner instances. press_pulse feeds the existing left/right pulse nets, and Reset is driven from ~SW[9].

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: Reset=0 with key_n=0 toggling → pressed=0, press_pulse=0 and release_pulse=0 throughout; state IDLE.
- Clean press: key_n 1→0 before edge k, held → exactly one press_pulse in the cycle after edge k+6; pressed=1 from then on; no further pulses while held for 50 cycles.
- Bounce reject: key_n low for 3 cycles then high → press_pulse never asserted; pressed stays 0.
- Release bounce: key_n goes high for 2 cycles while HELD, then low again → pressed stays 1, no release_pulse and no second press_pulse. A later clean release → one release_pulse 6 edges after the rising edge of key_n.
- Reset mid-hold: Reset asserted in HELD → pressed=0 immediately. Reset released with key still low → one press_pulse 6 edges after the first sampling edge.
- Rapid presses: two clean 10-cycle presses separated by 10 cycles → exactly two press_pulses and two release_pulses, each one cycle wide.
